// File: rtl/bcd_seg_pkg.sv
// Shared types and 7-segment constants for the BCD tick counter.
// Segment patterns are active-low, bit6=g ... bit0=a.
package bcd_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Clamp a non-BCD nibble (10..15) to 9.
    function automatic logic [3:0] sat9(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational BCD -> active-low 7-segment decode; codes 10..15 show blank.
module bcd_seg_lut
    import bcd_seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (i_bcd == 4'(i)) begin
                o_seg = SEG_DIGIT[i];
            end
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Prescaled single-digit BCD counter with RUN/PAUSE control and registered 7-seg output.
// Optional blanking blink while paused is enabled by defining BCD_TICK_BLINK_EN.
module bcd_tick_counter
    import bcd_seg_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_clear,
    input  logic       i_up,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic [3:0] o_digit,
    output logic       o_carry,
    output logic       o_running,
    output logic [6:0] o_seg
);

    localparam int              PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("bcd_tick_counter: TICK_DIV must be >= 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("bcd_tick_counter: BLINK_DIV must be >= 1");
    end

    state_e         r_state;
    state_e         w_state_nxt;
    logic [PW-1:0]  r_pre;
    logic [3:0]     r_digit;
    logic           r_carry;
    logic           r_running;
    logic [6:0]     r_seg;
    logic [6:0]     w_seg_lut;
    logic           w_step;
    logic           w_wrap;
    logic [3:0]     w_digit_step;
    logic           w_blank;

    // clear > load > stop > start; load leaves the state alone.
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = IDLE;
        end else if (i_load) begin
            w_state_nxt = r_state;
        end else if (i_stop) begin
            if (r_state == RUN) begin
                w_state_nxt = PAUSE;
            end
        end else if (i_start && (r_state != RUN)) begin
            w_state_nxt = RUN;
        end
    end

    assign w_step = (r_state == RUN) && (r_pre == PRE_LAST);

    always_comb begin
        w_digit_step = r_digit;
        w_wrap       = 1'b0;
        if (i_up) begin
            if (r_digit >= 4'd9) begin
                w_digit_step = 4'd0;
                w_wrap       = 1'b1;
            end else begin
                w_digit_step = r_digit + 4'd1;
            end
        end else begin
            if (r_digit == 4'd0) begin
                w_digit_step = 4'd9;
                w_wrap       = 1'b1;
            end else begin
                w_digit_step = r_digit - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_carry   <= 1'b0;
            r_digit   <= 4'd0;
            r_pre     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUN);
            r_carry   <= 1'b0;
            if (i_clear) begin
                r_digit <= 4'd0;
                r_pre   <= '0;
            end else if (i_load) begin
                r_digit <= sat9(i_load_val);
                r_pre   <= '0;
            end else begin
                if (w_step) begin
                    r_digit <= w_digit_step;
                    r_carry <= w_wrap;
                end
                // Prescaler is frozen in PAUSE so a resume keeps its phase.
                case (r_state)
                    RUN:     r_pre <= w_step ? '0 : r_pre + PW'(1);
                    PAUSE:   r_pre <= r_pre;
                    default: r_pre <= '0;
                endcase
            end
        end
    end

    bcd_seg_lut u_seg_lut (
        .i_bcd (r_digit),
        .o_seg (w_seg_lut)
    );

`ifdef BCD_TICK_BLINK_EN
    localparam int              BW         = (2 * BLINK_DIV > 2) ? $clog2(2 * BLINK_DIV) : 1;
    localparam logic [BW-1:0]   BLINK_LAST = BW'(2 * BLINK_DIV - 1);
    localparam logic [BW-1:0]   BLINK_HALF = BW'(BLINK_DIV);

    logic [BW-1:0] r_blink;

    // Held at zero outside PAUSE, so every pause starts on the visible half.
    always_ff @(posedge i_clk) begin
        if (i_rst || (r_state != PAUSE)) begin
            r_blink <= '0;
        end else if (r_blink == BLINK_LAST) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + BW'(1);
        end
    end

    assign w_blank = (r_state == PAUSE) && (r_blink >= BLINK_HALF);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg <= SEG_DIGIT[0];
        end else begin
            r_seg <= w_blank ? SEG_BLANK : w_seg_lut;
        end
    end

    assign o_digit   = r_digit;
    assign o_carry   = r_carry;
    assign o_running = r_running;
    assign o_seg     = r_seg;

endmodule
